data_memory_mmio: RTL

Data-side memory stage of the single-cycle MIPS core: consumes the datapath's ALU result as address, the register-file second read port as store data, and the control unit's MemWrite; returns Read_Data to the MemtoReg mux in the same cycle. Decodes a word-addressed RAM plus a small memory-mapped I/O page holding a GPIO register, a free-running cycle counter and a one-shot down-counting timer with a sticky expiry flag.

---
 rtl/data_memory_mmio_pkg.sv | 14 +
 rtl/data_memory_mmio_timer.sv | 39 +++
 rtl/data_memory_mmio.sv | 63 ++++++
 3 files changed

// File: rtl/data_memory_mmio_pkg.sv
// data_memory_mmio_pkg: IO page map, status bits and timer states.
package data_memory_mmio_pkg;
  localparam logic [31:0] IO_BASE = 32'h8000_0000;
  localparam logic [3:0] OFF_GPIO = 4'h0;
  localparam logic [3:0] OFF_CYCLES = 4'h4;
  localparam logic [3:0] OFF_TIMER = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;
  localparam int STAT_EXPIRED = 0;
  localparam int STAT_RUNNING = 1;
  typedef enum logic {IDLE, RUN} timer_state_e;
  function automatic logic [1:0] reg_idx(input logic [3:0] off);
    return off[3:2];
  endfunction
endpackage

// File: rtl/data_memory_mmio_timer.sv
// mmio_timer: one-shot down counter with sticky expiry flag.
module mmio_timer
  import data_memory_mmio_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         running_o,
  output logic         expired_o
);
  timer_state_e state_q;
  logic [W-1:0] count_q;
  logic expired_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      expired_q <= 1'b0;
    end else begin
      if (load_i) begin
        count_q <= load_val_i;
        state_q <= load_val_i != '0 ? RUN : IDLE;
      end else if (state_q == RUN) begin
        count_q <= count_q - W'(1);
        state_q <= count_q == W'(1) ? IDLE : RUN;
      end
      // a reload masks expiry; expiry beats a same-edge clear
      if (!load_i && state_q == RUN && count_q == W'(1)) expired_q <= 1'b1;
      else if (clr_i) expired_q <= 1'b0;
    end
  assign count_o = count_q;
  assign running_o = state_q == RUN;
  assign expired_o = expired_q;
endmodule

// File: rtl/data_memory_mmio.sv
// data_memory_mmio: word RAM plus GPIO/cycle-counter/timer IO page, combinational reads.
module data_memory_mmio
  import data_memory_mmio_pkg::*;
#(
  parameter int Data_Width = 32,
  parameter int Mem_Depth = 64,
  parameter int Timer_Width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mem_Write,
  input  logic [Data_Width-1:0] Address,
  input  logic [Data_Width-1:0] Write_Data,
  output logic [Data_Width-1:0] Read_Data,
  output logic [Data_Width-1:0] GPIO_Out,
  output logic                  Timer_Irq
);
  localparam int AW = $clog2(Mem_Depth);
  logic [Data_Width-1:0] ram_q [Mem_Depth];
  logic [Data_Width-1:0] gpio_q, gpio_d, cycles_q, cycles_d, status, io_rd;
  logic [Timer_Width-1:0] count;
  logic running, expired, is_ram, io_ok, unused_addr;
  logic [1:0] sel;
  logic [AW-1:0] idx;
  assign is_ram = ~Address[Data_Width-1];
  assign io_ok = Address[Data_Width-1:4] == (Data_Width-4)'(IO_BASE >> 4);
  assign sel = Address[3:2];
  assign idx = Address[AW+1:2];
  assign unused_addr = ^Address[1:0];
  assign cycles_d = cycles_q + Data_Width'(1);
  mmio_timer #(.W(Timer_Width)) u_timer (
    .clk,
    .rst(reset),
    .load_i(Mem_Write && io_ok && sel == reg_idx(OFF_TIMER)),
    .load_val_i(Write_Data[Timer_Width-1:0]),
    .clr_i(Mem_Write && io_ok && sel == reg_idx(OFF_STATUS) && Write_Data[STAT_EXPIRED]),
    .count_o(count),
    .running_o(running),
    .expired_o(expired)
  );
  always_comb begin
    status = '0;
    status[STAT_RUNNING] = running;
    status[STAT_EXPIRED] = expired;
    io_rd = sel == reg_idx(OFF_GPIO) ? gpio_q :
            sel == reg_idx(OFF_CYCLES) ? cycles_q :
            sel == reg_idx(OFF_TIMER) ? Data_Width'(count) : status;
    Read_Data = is_ram ? ram_q[idx] : io_ok ? io_rd : '0;
    gpio_d = Mem_Write && io_ok && sel == reg_idx(OFF_GPIO) ? Write_Data : gpio_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < Mem_Depth; i++) ram_q[i] <= '0;
      gpio_q <= '0;
      cycles_q <= '0;
    end else begin
      if (Mem_Write && is_ram) ram_q[idx] <= Write_Data;
      gpio_q <= gpio_d;
      cycles_q <= cycles_d;
    end
  assign GPIO_Out = gpio_q;
  assign Timer_Irq = expired;
endmodule
